fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- IF stage of each core's 5-stage pipeline; sits directly upstream of the hazard detection unit and consumes its freeze and threeInstrFlush outputs.
- Owns the PC register, the request handshake to the instruction cache (imemREN/imemaddr, ihit/imemload) and the IF/ID pipeline register.
- A one-entry skid buffer absorbs an ihit that lands while the pipeline is frozen.
- A DISCARD state drops a stale in-flight fetch after a branch/jump redirect.

Parameters:
- PC_INIT, 32'h0000_0000, reset PC value (core 1 instantiates with 32'h0000_0200).
- PC_STEP, 4, PC increment per sequential fetch.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- freeze  in  1  hold IF/ID and PC (load-use hazard)
- flush  in  1  threeInstrFlush: redirect fetch, squash IF/ID
- redirect_pc  in  32  target PC, valid when flush=1
- halt_req  in  1  decode saw HALT: stop fetching
- ihit  in  1  icache returns imemload this cycle
- imemload  in  32  instruction word
- imemREN  out  1  icache read request
- imemaddr  out  32  icache address
- ifid_valid  out  1  IF/ID holds a live instruction
- ifid_instr  out  32  IF/ID instruction
- ifid_pc  out  32  IF/ID PC
- ifid_npc  out  32  IF/ID PC+PC_STEP

Behaviour:
- Reset (async, nRST=0): pc=PC_INIT, state=FETCH, skid_valid=0, ifid_valid=0, ifid_instr/pc/npc=0, pending_pc=0. imemREN=0 only while nRST=0.
- Request rule: an issued request holds imemaddr constant until ihit. imemaddr=pc in FETCH and DISCARD.
- imemREN=1 in FETCH or DISCARD when skid_valid=0. imemREN=0 in HALTED or when skid_valid=1.
- Priority within a cycle: flush > halt_req > freeze > normal.

FETCH state:
- No flush, no freeze, ihit=1: IF/ID <= {1, imemload, pc, pc+PC_STEP}; pc <= pc+PC_STEP. Latency: ihit to ifid_valid is 1 cycle.
- No flush, no freeze, ihit=0: ifid_valid <= 0 (bubble); pc held.
- freeze=1: IF/ID held unchanged.
  - If ihit=1 and skid empty: skid <= {imemload, pc}; pc <= pc+PC_STEP; skid_valid <= 1.
  - If skid_valid=1: no request issued.
- freeze falls while skid_valid=1: IF/ID <= skid contents; skid_valid <= 0; fetching resumes the next cycle.
- flush=1 and ihit=1: drop imemload; pc <= redirect_pc; ifid_valid <= 0; skid_valid <= 0; stay FETCH.
- flush=1 and ihit=0: pending_pc <= redirect_pc; ifid_valid <= 0; skid_valid <= 0; go DISCARD. imemaddr stays at the old pc.
- flush with skid_valid=1: no request is outstanding, so pc <= redirect_pc directly and state stays FETCH.
- halt_req=1: ifid_valid <= 0; go HALTED. An in-flight word is dropped.

DISCARD state:
- Holds the old address until ihit.
- On ihit: word dropped; pc <= pending_pc; go FETCH.
- Another flush in DISCARD overwrites pending_pc (last redirect wins).
- ifid_valid stays 0 while in DISCARD.

HALTED state:
- imemREN=0; IF/ID valid=0. Exited only by reset.

General:
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- Reset mid-request: in-flight state is abandoned; the cache must tolerate imemREN dropping.

Optional Feature:
- FETCH_PERF_EN defined: adds outputs fetch_count[31:0] and discard_count[31:0].
  - fetch_count increments once per accepted instruction (IF/ID or skid load).
  - discard_count increments once per dropped ihit (flush+ihit, or DISCARD completion).
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- cpu_types_pkg gains:
  - fetch_state_t enum {FETCH, DISCARD, HALTED}
  - ifid_t packed struct {valid, instr, pc, npc}, using the existing word_t.
- One sub-module: fetch_skid_buffer, a one-entry {instr, pc} buffer with load/drain/clear.
- PC/FSM/IF-ID logic stays in fetch_unit.

Test Plan:
- Reset then ihit every cycle from PC_INIT=0 -> imemaddr 0,4,8; ifid_pc 0,4 one cycle after each ihit; ifid_npc=ifid_pc+4.
- freeze=1 for 3 cycles, ihit in the first, imemload=32'h00A00093 at pc=8 -> IF/ID held; imemREN=0 while skid full. freeze falls -> ifid_instr=32'h00A00093, ifid_pc=8; next request addr 12.
- flush=1, redirect_pc=32'h40, ihit=0 at pc=16 -> DISCARD; imemaddr holds 16. ihit 2 cycles later is dropped (ifid_valid=0); next imemaddr=32'h40.
- flush and ihit same cycle, redirect_pc=32'h80 -> ifid_valid=0 next cycle; imemaddr=32'h80 next cycle.
- flush and freeze same cycle with skid_valid=1 -> skid cleared, ifid_valid=0, pc=redirect_pc.
- halt_req=1 -> imemREN=0 forever; nRST pulse mid-DISCARD -> pc=PC_INIT, state FETCH, all IF/ID outputs 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch FSM states
// and the IF/ID pipeline register bundle.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      DISCARD = 2'd1,
      HALTED  = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic  valid;
      word_t instr;
      word_t pc;
      word_t npc;
   } ifid_t;

   function automatic word_t pc_add(input word_t pc, input word_t step);
      return pc + step;
   endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {instr, pc} holding slot for an ihit
// that lands while the pipeline is frozen.
module fetch_skid_buffer
   import cpu_types_pkg::*;
(
   input  logic  CLK,
   input  logic  nRST,
   input  logic  load,
   input  logic  drain,
   input  logic  clear,
   input  word_t load_instr,
   input  word_t load_pc,
   output logic  valid,
   output word_t instr,
   output word_t pc
);

   // Clear beats load, load beats drain.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         valid <= 1'b0;
         instr <= '0;
         pc    <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         instr <= load_instr;
         pc    <= load_pc;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC, icache request, skid slot and IF/ID register.
// Optional perf counters when FETCH_PERF_EN is defined.
module fetch_unit
   import cpu_types_pkg::*;
#(
   parameter word_t       PC_INIT = 32'h0000_0000,
   parameter int unsigned PC_STEP = 4
)
(
   input  logic        CLK,
   input  logic        nRST,
   input  logic        freeze,
   input  logic        flush,
   input  logic [31:0] redirect_pc,
   input  logic        halt_req,
   input  logic        ihit,
   input  logic [31:0] imemload,
   output logic        imemREN,
   output logic [31:0] imemaddr,
   output logic        ifid_valid,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_npc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] fetch_count,
   output logic [31:0] discard_count
`endif
);

   localparam word_t STEP = word_t'(PC_STEP);

   fetch_state_t state;
   word_t        pc;
   word_t        pending_pc;
   ifid_t        ifid_q;

   logic  sk_valid;
   word_t sk_instr;
   word_t sk_pc;
   logic  sk_load;
   logic  sk_drain;
   logic  sk_clear;

   word_t pc_next;
   assign pc_next = pc_add(pc, STEP);

   fetch_skid_buffer u_skid (
      .CLK        (CLK),
      .nRST       (nRST),
      .load       (sk_load),
      .drain      (sk_drain),
      .clear      (sk_clear),
      .load_instr (imemload),
      .load_pc    (pc),
      .valid      (sk_valid),
      .instr      (sk_instr),
      .pc         (sk_pc)
   );

   // Skid control: capture under freeze, hand over when freeze drops.
   always_comb begin
      sk_load  = 1'b0;
      sk_drain = 1'b0;
      sk_clear = 1'b0;
      if (state != FETCH) begin
         sk_clear = 1'b1;
      end else if (flush || halt_req) begin
         sk_clear = 1'b1;
      end else if (freeze) begin
         sk_load = ihit && !sk_valid;
      end else begin
         sk_drain = sk_valid;
      end
   end

   // Fetch FSM, PC and IF/ID register.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= FETCH;
         pc         <= PC_INIT;
         pending_pc <= '0;
         ifid_q     <= '0;
      end else begin
         unique case (state)
            FETCH: begin
               if (flush) begin
                  ifid_q.valid <= 1'b0;
                  if (sk_valid || ihit) begin
                     pc <= redirect_pc;
                  end else begin
                     pending_pc <= redirect_pc;
                     state      <= DISCARD;
                  end
               end else if (halt_req) begin
                  ifid_q.valid <= 1'b0;
                  state        <= HALTED;
               end else if (freeze) begin
                  if (ihit && !sk_valid) begin
                     pc <= pc_next;
                  end
               end else if (sk_valid) begin
                  ifid_q <= '{valid: 1'b1,
                             instr: sk_instr,
                             pc:    sk_pc,
                             npc:   pc_add(sk_pc, STEP)};
               end else if (ihit) begin
                  ifid_q <= '{valid: 1'b1,
                             instr: imemload,
                             pc:    pc,
                             npc:   pc_next};
                  pc     <= pc_next;
               end else begin
                  ifid_q.valid <= 1'b0;
               end
            end
            DISCARD: begin
               ifid_q.valid <= 1'b0;
               if (flush) begin
                  if (ihit) begin
                     pc    <= redirect_pc;
                     state <= FETCH;
                  end else begin
                     pending_pc <= redirect_pc;
                  end
               end else if (halt_req) begin
                  state <= HALTED;
               end else if (ihit) begin
                  pc    <= pending_pc;
                  state <= FETCH;
               end
            end
            HALTED: begin
               ifid_q.valid <= 1'b0;
            end
            default: begin
               state <= FETCH;
            end
         endcase
      end
   end

   assign imemREN    = nRST && (state != HALTED) && !sk_valid;
   assign imemaddr   = pc;
   assign ifid_valid = ifid_q.valid;
   assign ifid_instr = ifid_q.instr;
   assign ifid_pc    = ifid_q.pc;
   assign ifid_npc   = ifid_q.npc;

`ifdef FETCH_PERF_EN
   logic accept_ev;
   logic drop_ev;

   assign accept_ev = (state == FETCH) && !flush && !halt_req
                   && ihit && !sk_valid;
   assign drop_ev   = ihit
                   && (((state == FETCH) && flush && !sk_valid)
                    || ((state == DISCARD) && (flush || !halt_req)));

   // Saturating event counters.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         fetch_count   <= '0;
         discard_count <= '0;
      end else begin
         if (accept_ev && (fetch_count != 32'hFFFF_FFFF)) begin
            fetch_count <= fetch_count + 32'd1;
         end
         if (drop_ev && (discard_count != 32'hFFFF_FFFF)) begin
            discard_count <= discard_count + 32'd1;
         end
      end
   end
`endif

endmodule
